pci_bus_arbiter: RTL and testbench
==================================

# pci_bus_arbiter

Central PCI bus arbiter for the three bus agents (device A, B, C) on the shared address/data bus. It samples each agent's active-low request and drives one active-low grant at a time, using rotating (round-robin) priority. It watches FRAME#/IRDY# to track bus ownership and enforces the idle turnaround cycle between grants. It parks the bus on a default master when nobody requests. It sits beside the top-level bus model and replaces the forced-request stimulus currently used by the bench.

## Interface
Parameters:
- NUM_MASTERS, 3, number of agents (A=0, B=1, C=2); logic is sized for 3.
- PARK_MASTER, 0, index granted when no requests are pending.
- GNT_TIMEOUT, 16, idle clocks a non-parked grant may go unused before it is revoked.

Ports:
- clck  input  1  bus clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_n  input  3  per-agent request, active low.
- frame_n  input  1  bus FRAME#, active low.
- irdy_n  input  1  bus IRDY#, active low.
- gnt_n  output  3  per-agent grant, active low, at most one bit low; registered.
- owner  output  2  index of the master currently running a transaction; 2'd3 when none.
- bus_idle  output  1  registered copy of (frame_n & irdy_n).

## Operation
- Bus idle is defined as frame_n=1 and irdy_n=1.
- The state machine has four states:
  - IDLE: no grant asserted.
  - GRANT: gnt asserted to cur, waiting for FRAME#.
  - BUSY: transaction owned by cur.
  - TURN: one dead cycle with all gnt_n high.
- Winner selection: search indices last+1, last+2, last (mod 3) and take the first with req_n low. `last` is the master that most recently entered BUSY; its reset value is 2, so A wins first.
- IDLE:
  - Any request → GRANT with cur=winner, parked=0.
  - No request → GRANT with cur=PARK_MASTER, parked=1.
- GRANT:
  - frame_n low while the bus was idle the previous cycle → BUSY; owner=cur, last=cur.
  - Parked and any request pending from another master → TURN.
  - Parked and PARK_MASTER itself requests → stay in GRANT, parked=0, timer cleared.
  - Not parked, req_n[cur] high, and another request pending → TURN.
  - Not parked and timer reaches GNT_TIMEOUT with frame_n still high → TURN; `last` is set to cur so that agent loses priority.
- BUSY:
  - gnt_n[cur] stays low while no other agent requests.
  - When another agent requests, gnt_n[cur] is driven high (the owner's latency timer then ends the burst). The owner remains owner until the bus returns to idle.
  - Bus returns to idle: if req_n[cur] is low and no other request is pending → GRANT (same cur, back-to-back); otherwise → TURN.
  - owner returns to 3 on that edge.
- TURN: all gnt_n high for exactly one cycle, then → IDLE.
- Invariants:
  - Never more than one gnt_n bit low.
  - Never a direct gnt change from one agent to another without an all-high cycle in between.

## Timing
- Reset values: gnt_n=3'b111, owner=2'd3, bus_idle=1, state=IDLE, last=2, timer=0, parked=0.
- Reset is asynchronous mid-transaction: all grants release immediately, with no wait for bus idle.
- Request-to-grant latency from IDLE: request sampled at edge k; gnt_n low after edge k+1 (IDLE→GRANT at k, outputs registered).
- Grant handoff, idle bus: at least 1 all-high cycle (TURN), then 1 cycle in IDLE, so the new grant appears 2 clocks after the old one drops.
- The timer increments once per clock in GRANT while not parked and frame_n is high. It clears on entering GRANT, and on frame_n low.
- Simultaneous events:
  - Bus-idle return plus a new request in the same cycle: the rotation rule applies, so the just-finished owner is lowest priority.
  - req_n changes during TURN are ignored until IDLE samples them.
- frame_n asserted by a non-granted agent is ignored: no state change, owner unchanged.

## Structure
- Package pci_arb_pkg holds:
  - typedef enum for the states: IDLE, GRANT, BUSY, TURN.
  - typedef for the 2-bit master index.
  - constants MASTER_A=0, MASTER_B=1, MASTER_C=2, NO_OWNER=3.
- Sub-module pci_rr_select: combinational round-robin picker. Inputs: req vector (active high) and last index. Outputs: winner index and any_req.
- The top module holds the FSM, timer, parked flag and output registers.

## Test plan
- Reset then idle: no requests for 5 clocks → gnt_n=3'b110 (parked on A) from the second clock; owner=3.
- Single requester B:
  - req_n=3'b101: TURN out of park, then gnt_n=3'b101.
  - B drives frame_n low for 4 clocks → owner=1 during the burst, then 3.
- Three simultaneous requests (req_n=3'b000), each agent running a 2-clock FRAME# burst → grants issued in order A, B, C, A. Each handoff has one clock with gnt_n=3'b111.
- Preemption: A owns the bus and C raises a request mid-burst → gnt_n[0] goes high the next clock while owner stays 0 until the bus is idle; C is granted 2 clocks after idle.
- Unused grant: B is granted but never asserts FRAME# → grant revoked after 16 clocks; C (also requesting) is granted next.
- Reset mid-burst: rst_n low while owner=2 → gnt_n=3'b111 and owner=3 asynchronously. After release, A wins first.

Source files
------------

// File: rtl/pci_arb_pkg.sv
// Shared types and constants for the three-agent PCI bus arbiter.
//   arb_state_t  : arbiter FSM states
//   master_idx_t : 2-bit agent index (A=0, B=1, C=2, 3 = no owner)
package pci_arb_pkg;

  localparam int unsigned IDX_W = 2;

  typedef logic [IDX_W-1:0] master_idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2,
    TURN  = 2'd3
  } arb_state_t;

  localparam master_idx_t MASTER_A = 2'd0;
  localparam master_idx_t MASTER_B = 2'd1;
  localparam master_idx_t MASTER_C = 2'd2;
  localparam master_idx_t NO_OWNER = 2'd3;

endpackage

// File: rtl/pci_rr_select.sv
// Combinational round-robin picker.
//   req_i     : per-agent request, active high
//   last_i    : agent that most recently owned the bus (lowest priority)
//   winner_o  : first requester searching last+1, last+2, last (mod N)
//   any_req_o : at least one request pending
module pci_rr_select
  import pci_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 3
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [IDX_W-1:0]       last_i,
  output logic [IDX_W-1:0]       winner_o,
  output logic                   any_req_o
);

  // Rotating search; the offset loop wraps so `last` is examined last.
  always_comb begin
    logic        found;
    master_idx_t cand;
    winner_o = last_i;
    found    = 1'b0;
    cand     = last_i;
    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
      cand = IDX_W'((32'(last_i) + k) % NUM_MASTERS);
      if (!found && req_i[cand]) begin
        winner_o = cand;
        found    = 1'b1;
      end
    end
  end

  assign any_req_o = |req_i;

endmodule

// File: rtl/pci_bus_arbiter.sv
// Central PCI bus arbiter for agents A, B, C with rotating priority,
// bus parking, unused-grant timeout and a dead cycle between grants.
//   clck     : bus clock, rising edge
//   rst_n    : asynchronous active-low reset
//   req_n    : per-agent request, active low
//   frame_n  : bus FRAME#, active low
//   irdy_n   : bus IRDY#, active low
//   gnt_n    : per-agent grant, active low, at most one low, registered
//   owner    : agent running the current transaction, 3 when none
//   bus_idle : registered (frame_n & irdy_n)
module pci_bus_arbiter
  import pci_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 3,
  parameter int unsigned PARK_MASTER = 0,
  parameter int unsigned GNT_TIMEOUT = 16
) (
  input  logic                   clck,
  input  logic                   rst_n,
  input  logic [NUM_MASTERS-1:0] req_n,
  input  logic                   frame_n,
  input  logic                   irdy_n,
  output logic [NUM_MASTERS-1:0] gnt_n,
  output logic [IDX_W-1:0]       owner,
  output logic                   bus_idle
);

  localparam int unsigned TIMER_W = $clog2(GNT_TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_VAL = TIMER_W'(GNT_TIMEOUT);
  localparam master_idx_t PARK_IDX = IDX_W'(PARK_MASTER);

  arb_state_t             state_q, state_d;
  master_idx_t            cur_q, cur_d;
  master_idx_t            last_q, last_d;
  master_idx_t            owner_q, owner_d;
  logic [TIMER_W-1:0]     timer_q, timer_d;
  logic [TIMER_W-1:0]     timer_inc;
  logic                   parked_q, parked_d;
  logic [NUM_MASTERS-1:0] gnt_n_q, gnt_n_d;
  logic                   bus_idle_q;

  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] cur_oh;
  logic                   other_req;
  logic                   any_req;
  master_idx_t            winner;

  function automatic logic [NUM_MASTERS-1:0] idx_onehot(input master_idx_t idx);
    logic [NUM_MASTERS-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  assign req       = ~req_n;
  assign cur_oh    = idx_onehot(cur_q);
  assign other_req = |(req & ~cur_oh);
  assign timer_inc = timer_q + TIMER_W'(1);

  pci_rr_select #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_rr_select (
    .req_i     (req),
    .last_i    (last_q),
    .winner_o  (winner),
    .any_req_o (any_req)
  );

  // Next state; gnt_n_d follows the current state so the grant pins lag
  // the FSM by one clock, giving one-cycle grant latency out of IDLE.
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    last_d   = last_q;
    owner_d  = owner_q;
    timer_d  = timer_q;
    parked_d = parked_q;
    gnt_n_d  = '1;
    unique case (state_q)
      IDLE: begin
        state_d = GRANT;
        timer_d = '0;
        if (any_req) begin
          cur_d    = winner;
          parked_d = 1'b0;
        end else begin
          cur_d    = PARK_IDX;
          parked_d = 1'b1;
        end
      end
      GRANT: begin
        gnt_n_d = ~cur_oh;
        // Only a start by the agent whose grant is actually on the pins counts.
        if (!frame_n && bus_idle_q && !gnt_n_q[cur_q]) begin
          state_d  = BUSY;
          owner_d  = cur_q;
          last_d   = cur_q;
          parked_d = 1'b0;
          timer_d  = '0;
        end else if (parked_q) begin
          if (other_req) begin
            state_d = TURN;
          end else if (req[cur_q]) begin
            parked_d = 1'b0;
            timer_d  = '0;
          end
        end else if (!req[cur_q] && other_req) begin
          state_d = TURN;
        end else if (!frame_n) begin
          timer_d = '0;
        end else if (timer_inc == TIMEOUT_VAL) begin
          // Revoke the idle grant and demote this agent in the rotation.
          state_d = TURN;
          last_d  = cur_q;
        end else begin
          timer_d = timer_inc;
        end
      end
      BUSY: begin
        // Pull the grant early so the owner's latency timer ends the burst.
        gnt_n_d = other_req ? '1 : ~cur_oh;
        if (frame_n && irdy_n) begin
          owner_d = NO_OWNER;
          if (req[cur_q] && !other_req) begin
            state_d  = GRANT;
            parked_d = 1'b0;
            timer_d  = '0;
          end else begin
            state_d = TURN;
          end
        end
      end
      TURN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clck or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cur_q      <= PARK_IDX;
      last_q     <= MASTER_C;
      owner_q    <= NO_OWNER;
      timer_q    <= '0;
      parked_q   <= 1'b0;
      gnt_n_q    <= '1;
      bus_idle_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      timer_q    <= timer_d;
      parked_q   <= parked_d;
      gnt_n_q    <= gnt_n_d;
      bus_idle_q <= frame_n & irdy_n;
    end
  end

  assign gnt_n    = gnt_n_q;
  assign owner    = owner_q;
  assign bus_idle = bus_idle_q;

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Directed bench for pci_bus_arbiter with hand-computed expectations.
module tb_pci_bus_arbiter;

  logic       clck = 1'b0;
  logic       rst_n;
  logic [2:0] req_n;
  logic       frame_n;
  logic       irdy_n;
  logic [2:0] gnt_n;
  logic [1:0] owner;
  logic       bus_idle;

  int checks = 0;
  int errors = 0;

  always #5 clck = ~clck;

  pci_bus_arbiter #(
    .NUM_MASTERS (3),
    .PARK_MASTER (0),
    .GNT_TIMEOUT (16)
  ) dut (
    .clck     (clck),
    .rst_n    (rst_n),
    .req_n    (req_n),
    .frame_n  (frame_n),
    .irdy_n   (irdy_n),
    .gnt_n    (gnt_n),
    .owner    (owner),
    .bus_idle (bus_idle)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clck);
    #1;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
  endtask

  // Wait (bounded) for the next grant and check who got it.
  task automatic wait_grant(input string tag, input logic [2:0] exp_gnt);
    int gap  = 0;
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step(1);
      if (gnt_n === 3'b111) gap++;
      else seen = 1'b1;
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    chk(tag, 32'(gnt_n), 32'(exp_gnt));
    chk({tag, "_gap"}, 32'(gap >= 1), 32'd1);
  endtask

  // Drive a FRAME#/IRDY# burst of n clocks, checking owner each clock.
  task automatic burst(input string tag, input logic [1:0] exp_owner, input int n);
    frame_n = 1'b0;
    irdy_n  = 1'b0;
    for (int i = 0; i < n; i++) begin
      step(1);
      chk(tag, 32'(owner), 32'(exp_owner));
    end
    frame_n = 1'b1;
    irdy_n  = 1'b1;
  endtask

  // Invariants: one grant at most, and no direct agent-to-agent grant change.
  logic [2:0] prev_gnt = 3'b111;
  always @(negedge clck) begin
    if (rst_n === 1'b1) begin
      chk("one_grant", 32'($countones(~gnt_n) <= 1), 32'd1);
      if (prev_gnt !== 3'b111 && gnt_n !== 3'b111)
        chk("handoff", 32'(gnt_n), 32'(prev_gnt));
    end
    prev_gnt = gnt_n;
  end

  initial begin
    int cnt;
    bit done;
    rst_n   = 1'b0;
    req_n   = 3'b111;
    frame_n = 1'b1;
    irdy_n  = 1'b1;

    // Reset values, then parking on A.
    step(2);
    chk("rst_gnt", 32'(gnt_n), 32'h7);
    chk("rst_owner", 32'(owner), 32'd3);
    chk("rst_idle", 32'(bus_idle), 32'd1);
    rst_n = 1'b1;
    step(1);
    chk("park_first", 32'(gnt_n), 32'h7);
    step(1);
    chk("park_a", 32'(gnt_n), 32'h6);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("park_hold", 32'(gnt_n), 32'h6);
      chk("park_owner", 32'(owner), 32'd3);
    end

    // Single requester B leaves the park through TURN.
    req_n = 3'b101;
    step(1); chk("b_park_still", 32'(gnt_n), 32'h6);
    step(1); chk("b_turn", 32'(gnt_n), 32'h7);
    step(1); chk("b_idle", 32'(gnt_n), 32'h7);
    step(1); chk("b_grant", 32'(gnt_n), 32'h5);
    req_n = 3'b111;
    burst("b_owner", 2'd1, 4);
    chk("b_busy_flag", 32'(bus_idle), 32'd0);
    step(1);
    chk("b_owner_end", 32'(owner), 32'd3);
    chk("b_gnt_last", 32'(gnt_n), 32'h5);
    step(1);
    chk("b_release", 32'(gnt_n), 32'h7);

    // All three request: rotation A, B, C, A.
    req_n = 3'b000;
    reset_pulse();
    wait_grant("rr_a1", 3'b110);
    burst("rr_own_a", 2'd0, 2);
    wait_grant("rr_b", 3'b101);
    burst("rr_own_b", 2'd1, 2);
    wait_grant("rr_c", 3'b011);
    burst("rr_own_c", 2'd2, 2);
    wait_grant("rr_a2", 3'b110);

    // Preemption: C requests while A is mid-burst.
    req_n   = 3'b111;
    frame_n = 1'b0;
    irdy_n  = 1'b0;
    step(1);
    chk("pre_owner0", 32'(owner), 32'd0);
    chk("pre_gnt0", 32'(gnt_n), 32'h6);
    chk("pre_busy", 32'(bus_idle), 32'd0);
    req_n = 3'b011;
    step(1);
    chk("pre_gnt_drop", 32'(gnt_n), 32'h7);
    chk("pre_owner1", 32'(owner), 32'd0);
    step(1);
    chk("pre_owner2", 32'(owner), 32'd0);
    frame_n = 1'b1;
    irdy_n  = 1'b1;
    step(1);
    chk("pre_owner_end", 32'(owner), 32'd3);
    chk("pre_idle", 32'(bus_idle), 32'd1);
    step(1); chk("pre_dead1", 32'(gnt_n), 32'h7);
    step(1); chk("pre_dead2", 32'(gnt_n), 32'h7);
    step(1); chk("pre_gnt_c", 32'(gnt_n), 32'h3);

    // Unused grant: B never starts, C waits behind it.
    req_n = 3'b001;
    reset_pulse();
    cnt  = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      step(1);
      if (gnt_n === 3'b101) cnt++;
      else if (cnt > 0) done = 1'b1;
    end
    chk("unused_len", 32'(cnt), 32'd16);
    chk("unused_rel", 32'(gnt_n), 32'h7);
    wait_grant("unused_next_c", 3'b011);

    // Asynchronous reset while C owns the bus.
    req_n   = 3'b011;
    frame_n = 1'b0;
    irdy_n  = 1'b0;
    step(1);
    chk("arst_owner_c", 32'(owner), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_gnt", 32'(gnt_n), 32'h7);
    chk("arst_owner", 32'(owner), 32'd3);
    frame_n = 1'b1;
    irdy_n  = 1'b1;
    req_n   = 3'b000;
    step(1);
    rst_n = 1'b1;
    step(2);
    chk("arst_first_a", 32'(gnt_n), 32'h6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
